// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Serial receive core for an idle-high, already-synchronized serial line.
//   Detects a 1->0 start edge, times bits with an internal counter, samples at
//   bit centres, shifts data in LSB-first, checks the stop bit and presents a
//   held byte with ready / overrun / framing status to a downstream consumer.
//
// Ports
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset
//   serial_in     in   synchronized serial line, idle high
//   data_read     in   one-cycle strobe: consumer has taken rx_data
//   rx_data       out  last correctly framed payload, LSB = first bit received
//   data_ready    out  rx_data holds an unread byte
//   overrun_error out  a new byte was loaded while the previous was unread
//   framing_error out  last frame had stop bit = 0
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 serial_in,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 overrun_error,
   output logic                 framing_error
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(DATA_BITS) + 1;

   // Decisions are taken one edge after the nominal sample point using the
   // history flop, so the start check fires at count HALF rather than HALF-1.
   localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      LOAD
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 ready_q, ready_d;
   logic                 ovr_q, ovr_d;
   logic                 ferr_q, ferr_d;
   logic                 prev_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '1;
         rx_data_q <= '1;
         ready_q   <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
         prev_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         ready_q   <= ready_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
         prev_q    <= serial_in;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      ready_d   = ready_q;
      ovr_d     = ovr_q;
      ferr_d    = ferr_q;

      // Consumer acknowledge; a load in the same cycle overrides below.
      if (data_read) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (prev_q && !serial_in) begin
               state_d = START;
               ferr_d  = 1'b0;
            end
         end
         START: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == HALF) begin
               cnt_d = '0;
               bit_d = '0;
               // Line back high at mid start bit: glitch, not a frame.
               state_d = prev_q ? IDLE : DATA;
            end
         end
         DATA: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d                = '0;
               shift_d              = shift_q >> 1;
               shift_d[DATA_BITS-1] = prev_q;
               if (bit_q == BLAST) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         STOP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (prev_q) begin
                  state_d = LOAD;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         LOAD: begin
            rx_data_d = shift_q;
            ready_d   = 1'b1;
            ovr_d     = ready_q & ~data_read;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rx_data       = rx_data_q;
   assign data_ready    = ready_q;
   assign overrun_error = ovr_q;
   assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core. A timeline model records the serial line
//   per clock edge and derives output status from the frame timing rules
//   (T0, bit-centre offsets, Ts); a compare process checks every cycle, and
//   literal expectations pin key points of each scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

   localparam int unsigned DB  = 8;
   localparam int unsigned CPB = 10;
   localparam int unsigned H   = CPB / 2;
   localparam int unsigned HN  = 16384;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          serial_in;
   logic          data_read;
   logic [DB-1:0] rx_data;
   logic          data_ready;
   logic          overrun_error;
   logic          framing_error;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   uart_rx_core #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .serial_in     (serial_in),
      .data_read     (data_read),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .framing_error (framing_error)
   );

   always #5 clk = ~clk;

   // ---------------- timeline model ----------------
   bit            hist [HN];
   int unsigned   cyc   = 0;
   int unsigned   t0    = 0;
   int unsigned   ts    = 0;
   bit            busy  = 1'b0;
   bit            mprev = 1'b1;
   logic [DB-1:0] m_data = '1;
   logic          m_ready = 1'b0;
   logic          m_ovr   = 1'b0;
   logic          m_ferr  = 1'b0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy    = 1'b0;
         mprev   = 1'b1;
         m_data  = '1;
         m_ready = 1'b0;
         m_ovr   = 1'b0;
         m_ferr  = 1'b0;
      end else begin
         bit load_now;
         bit cur;
         load_now = 1'b0;
         cyc = cyc + 1;
         cur = serial_in;
         hist[cyc % HN] = cur;
         if (busy) begin
            if (cyc == t0 + H + 1 && hist[(t0 + H) % HN] == 1'b1) busy = 1'b0;
            if (cyc == ts + 1 && hist[ts % HN] == 1'b0) begin
               m_ferr = 1'b1;
               busy   = 1'b0;
            end
            if (cyc == ts + 2) begin
               load_now = 1'b1;
               busy     = 1'b0;
            end
         end else if (mprev && !cur) begin
            t0     = cyc;
            ts     = t0 + H + (DB + 1) * CPB;
            busy   = 1'b1;
            m_ferr = 1'b0;
         end
         if (load_now) begin
            for (int i = 0; i < int'(DB); i++)
               m_data[i] = hist[(t0 + H + (i + 1) * CPB) % HN];
            m_ovr   = m_ready && !data_read;
            m_ready = 1'b1;
         end else if (data_read) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
         end
         mprev = cur;
      end
   end

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("model rx_data",       16'(rx_data),       16'(m_data));
         cmp("model data_ready",    16'(data_ready),    16'(m_ready));
         cmp("model overrun_error", 16'(overrun_error), 16'(m_ovr));
         cmp("model framing_error", 16'(framing_error), 16'(m_ferr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic data_stop(input logic [7:0] d, input logic stop, input int stop_cycles);
      for (int i = 0; i < int'(DB); i++) begin
         serial_in = d[i];
         tick(CPB);
      end
      serial_in = stop;
      tick(stop_cycles);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      serial_in = 1'b0;
      tick(CPB);
      data_stop(d, stop, CPB);
   endtask

   task automatic pulse_read;
      data_read = 1'b1;
      tick(1);
      data_read = 1'b0;
   endtask

   initial begin
      n_rst     = 1'b0;
      serial_in = 1'b1;
      data_read = 1'b0;
      tick(3);
      cmp("reset rx_data",  16'(rx_data), 16'h00FF);
      cmp("reset ready",    16'(data_ready), 16'h0);
      cmp("reset overrun",  16'(overrun_error), 16'h0);
      cmp("reset framing",  16'(framing_error), 16'h0);
      #2 n_rst = 1'b1;
      chk_en = 1'b1;
      tick(5);

      // 0xA5: ready must rise exactly at edge T0+97
      serial_in = 1'b0;
      tick(CPB);
      data_stop(8'hA5, 1'b1, 7);
      cmp("A5 ready before T0+97", 16'(data_ready), 16'h0);
      tick(1);
      cmp("A5 ready at T0+97", 16'(data_ready), 16'h1);
      cmp("A5 rx_data", 16'(rx_data), 16'h00A5);
      cmp("A5 framing", 16'(framing_error), 16'h0);
      tick(2);
      pulse_read;
      cmp("A5 read clears ready", 16'(data_ready), 16'h0);
      tick(4);

      // Framing error, then recovery frame 0x01
      send_frame(8'h3C, 1'b0);
      cmp("3C framing set", 16'(framing_error), 16'h1);
      cmp("3C rx unchanged", 16'(rx_data), 16'h00A5);
      cmp("3C ready unchanged", 16'(data_ready), 16'h0);
      serial_in = 1'b1;
      tick(6);
      serial_in = 1'b0;
      tick(1);
      cmp("01 framing cleared at T0", 16'(framing_error), 16'h0);
      tick(CPB - 1);
      data_stop(8'h01, 1'b1, CPB);
      cmp("01 rx_data", 16'(rx_data), 16'h0001);
      pulse_read;

      // Back-to-back frames without read -> overrun
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      serial_in = 1'b1;
      cmp("b2b rx_data", 16'(rx_data), 16'h0022);
      cmp("b2b ready", 16'(data_ready), 16'h1);
      cmp("b2b overrun", 16'(overrun_error), 16'h1);
      tick(3);
      pulse_read;
      cmp("b2b read ready", 16'(data_ready), 16'h0);
      cmp("b2b read overrun", 16'(overrun_error), 16'h0);
      tick(3);

      // 3-cycle glitch: false start, no status change
      serial_in = 1'b0;
      tick(3);
      serial_in = 1'b1;
      tick(20);
      cmp("glitch ready", 16'(data_ready), 16'h0);
      cmp("glitch rx_data", 16'(rx_data), 16'h0022);

      // Read strobe in the LOAD cycle of the second frame
      send_frame(8'h5A, 1'b1);
      serial_in = 1'b1;
      tick(4);
      serial_in = 1'b0;
      tick(CPB);
      data_stop(8'hC3, 1'b1, 7);
      data_read = 1'b1;
      tick(1);
      data_read = 1'b0;
      cmp("LOAD+read ready", 16'(data_ready), 16'h1);
      cmp("LOAD+read overrun", 16'(overrun_error), 16'h0);
      cmp("LOAD+read rx_data", 16'(rx_data), 16'h00C3);
      tick(2);
      serial_in = 1'b1;
      tick(3);

      // Line held low after framing error: no retrigger
      send_frame(8'h77, 1'b0);
      tick(300);
      cmp("held low framing", 16'(framing_error), 16'h1);
      cmp("held low rx_data", 16'(rx_data), 16'h00C3);
      cmp("held low ready", 16'(data_ready), 16'h1);
      serial_in = 1'b1;
      tick(4);
      send_frame(8'h0F, 1'b1);
      serial_in = 1'b1;
      cmp("after low rx_data", 16'(rx_data), 16'h000F);
      cmp("after low overrun", 16'(overrun_error), 16'h1);
      cmp("after low framing", 16'(framing_error), 16'h0);
      tick(3);

      // Asynchronous reset mid-DATA
      serial_in = 1'b0;
      tick(CPB);
      serial_in = 1'b1;
      tick(25);
      #2 n_rst = 1'b0;
      #1;
      cmp("async rst rx_data", 16'(rx_data), 16'h00FF);
      cmp("async rst ready", 16'(data_ready), 16'h0);
      cmp("async rst overrun", 16'(overrun_error), 16'h0);
      cmp("async rst framing", 16'(framing_error), 16'h0);
      serial_in = 1'b1;
      tick(3);
      #2 n_rst = 1'b1;
      tick(5);

      // Frame after reset
      send_frame(8'h96, 1'b1);
      serial_in = 1'b1;
      tick(3);
      cmp("post-rst rx_data", 16'(rx_data), 16'h0096);
      cmp("post-rst overrun", 16'(overrun_error), 16'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
